// File: rtl/aes_inv_key_schedule_if.sv
// rtl/aes_inv_key_schedule_if.sv - start/key input and round-key valid/ready stream of the inverse key schedule
interface aes_inv_key_schedule_if;
    logic         start_in;
    logic [127:0] key_in;
    logic         round_ready_in;
    logic         round_valid_out;
    logic [127:0] round_key_out;
    logic [3:0]   round_out;
    logic         busy_out;
    logic         done_out;

    modport master (
        output start_in, key_in, round_ready_in,
        input  round_valid_out, round_key_out, round_out, busy_out, done_out
    );

    modport slave (
        input  start_in, key_in, round_ready_in,
        output round_valid_out, round_key_out, round_out, busy_out, done_out
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - iterative inverse AES-128 key expansion, round keys 10..0; AES_INV_KS_SBOX_REG_EN registers the S-box stage
module aes_inv_key_schedule (
    input  logic                  clk_in,
    input  logic                  rst_in,
    aes_inv_key_schedule_if.slave ks
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_INV_KS_SBOX_REG_EN
    typedef enum logic [1:0] {S_IDLE, S_OUT, S_STEP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_OUT} state_t;
`endif

    state_t       state;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;
`ifdef AES_INV_KS_SBOX_REG_EN
    logic [31:0]  sub_q;
`endif

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Key is stored row-major, so a column word gathers one byte from each row.
    function automatic logic [31:0] col(input logic [127:0] k, input int c);
        return {k[127-8*c -: 8], k[95-8*c -: 8], k[63-8*c -: 8], k[31-8*c -: 8]};
    endfunction

    function automatic logic [127:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] w [4];
        logic [127:0] k;
        w = '{c0, c1, c2, c3};
        k = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                k[127-8*(4*r+c) -: 8] = w[c][31-8*r -: 8];
        return k;
    endfunction

    logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3, sub_word;
    logic [127:0] prev_key;

    always_comb begin
        w0       = col(key_q, 0);
        w1       = col(key_q, 1);
        w2       = col(key_q, 2);
        w3       = col(key_q, 3);
        p3       = w3 ^ w2;
        p2       = w2 ^ w1;
        p1       = w1 ^ w0;
        sub_word = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
`ifdef AES_INV_KS_SBOX_REG_EN
        p0       = w0 ^ sub_q ^ {rcon(round_q), 24'h0};
`else
        p0       = w0 ^ sub_word ^ {rcon(round_q), 24'h0};
`endif
        prev_key = pack(p0, p1, p2, p3);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= S_IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_INV_KS_SBOX_REG_EN
            sub_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (ks.start_in) begin
                    key_q   <= ks.key_in;
                    round_q <= 4'd10;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state   <= S_OUT;
                end
                S_OUT: if (ks.round_ready_in) begin
                    if (round_q == 4'd0) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
`ifdef AES_INV_KS_SBOX_REG_EN
                        sub_q   <= sub_word;
                        valid_q <= 1'b0;
                        state   <= S_STEP;
`else
                        key_q   <= prev_key;
                        round_q <= round_q - 4'd1;
`endif
                    end
                end
`ifdef AES_INV_KS_SBOX_REG_EN
                S_STEP: begin
                    key_q   <= prev_key;
                    round_q <= round_q - 4'd1;
                    valid_q <= 1'b1;
                    state   <= S_OUT;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ks.round_valid_out = valid_q;
    assign ks.round_key_out   = key_q;
    assign ks.round_out       = round_q;
    assign ks.busy_out        = busy_q;
    assign ks.done_out        = done_q;
endmodule
